// File: rtl/cordic_pipe_param.sv
// Fully pipelined CORDIC (rotation / vectoring per sample) with quadrant pre-rotation,
// optional gain compensation, output saturation and valid/ready backpressure.
module cordic_pipe_param #(
    parameter int unsigned W         = 20,
    parameter int unsigned ANGLE_W   = 21,
    parameter int unsigned ITER      = 10,
    parameter int unsigned GAIN_COMP = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      mode_i,
    input  logic signed [W-1:0]       x_i,
    input  logic signed [W-1:0]       y_i,
    input  logic signed [ANGLE_W-1:0] angle_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic signed [W-1:0]       x_o,
    output logic signed [W-1:0]       y_o,
    output logic signed [ANGLE_W-1:0] z_o
);

    localparam int unsigned XW = W + 2;
    localparam int unsigned ZW = ANGLE_W + 1;

    localparam logic signed [ZW-1:0] Deg90  = ZW'(90 * 4096);
    localparam logic signed [ZW-1:0] Deg180 = ZW'(180 * 4096);
    localparam logic signed [XW-1:0] SatMax = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] SatMin = {3'b111, {(W-1){1'b0}}};

    // atan(2^-i) in degrees, Q.12, rounded to nearest
    function automatic logic signed [ZW-1:0] atan_q12(input int unsigned i);
        int unsigned v;
        case (i)
            0:       v = 184320;
            1:       v = 108810;
            2:       v = 57492;
            3:       v = 29184;
            4:       v = 14649;
            5:       v = 7331;
            6:       v = 3667;
            7:       v = 1833;
            8:       v = 917;
            9:       v = 458;
            10:      v = 229;
            11:      v = 115;
            12:      v = 57;
            13:      v = 29;
            14:      v = 14;
            15:      v = 7;
            default: v = 0;
        endcase
        return ZW'(v);
    endfunction

    // Rotation steers z toward 0, vectoring steers y toward 0
    function automatic logic dir_pos(input logic md, input logic signed [XW-1:0] y,
                                     input logic signed [ZW-1:0] z);
        return md ? y[XW-1] : ~z[ZW-1];
    endfunction

    // K ~= 0.60725 as 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13
    function automatic logic signed [XW-1:0] scale_k(input logic signed [XW-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SatMax) return SatMax[W-1:0];
        if (v < SatMin) return SatMin[W-1:0];
        return v[W-1:0];
    endfunction

    logic advance;
    assign advance    = ~out_valid_o | out_ready_i;
    assign in_ready_o = advance;

    // Index 0 is the pre-rotation stage, index k holds the result of micro-rotation k-1
    logic [ITER:0]          vld_d, vld_q;
    logic [ITER-1:0]        md_d, md_q;
    logic signed [XW-1:0]   x_d [ITER+1];
    logic signed [XW-1:0]   x_q [ITER+1];
    logic signed [XW-1:0]   y_d [ITER+1];
    logic signed [XW-1:0]   y_q [ITER+1];
    logic signed [ZW-1:0]   z_d [ITER+1];
    logic signed [ZW-1:0]   z_q [ITER+1];

    logic signed [XW-1:0] x_ext, y_ext;
    logic signed [ZW-1:0] a_ext, pre_z;
    logic                 pre_neg;

    assign x_ext = {{2{x_i[W-1]}}, x_i};
    assign y_ext = {{2{y_i[W-1]}}, y_i};
    assign a_ext = {angle_i[ANGLE_W-1], angle_i};

    always_comb begin
        pre_neg = 1'b0;
        pre_z   = a_ext;
        if (mode_i) begin
            if (x_i[W-1]) begin
                pre_neg = 1'b1;
                pre_z   = y_i[W-1] ? a_ext - Deg180 : a_ext + Deg180;
            end
        end else if (a_ext > Deg90) begin
            pre_neg = 1'b1;
            pre_z   = a_ext - Deg180;
        end else if (a_ext < -Deg90) begin
            pre_neg = 1'b1;
            pre_z   = a_ext + Deg180;
        end
    end

    always_comb begin
        vld_d = '0;
        md_d  = '0;
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;

        vld_d[0] = in_valid_i;
        md_d[0]  = mode_i;
        x_d[0]   = pre_neg ? -x_ext : x_ext;
        y_d[0]   = pre_neg ? -y_ext : y_ext;
        z_d[0]   = pre_z;

        for (int k = 1; k < int'(ITER); k++) begin
            md_d[k] = md_q[k-1];
        end

        for (int k = 1; k <= int'(ITER); k++) begin
            vld_d[k] = vld_q[k-1];
            if (dir_pos(md_q[k-1], y_q[k-1], z_q[k-1])) begin
                x_d[k] = x_q[k-1] - (y_q[k-1] >>> (k - 1));
                y_d[k] = y_q[k-1] + (x_q[k-1] >>> (k - 1));
                z_d[k] = z_q[k-1] - atan_q12(unsigned'(k - 1));
            end else begin
                x_d[k] = x_q[k-1] + (y_q[k-1] >>> (k - 1));
                y_d[k] = y_q[k-1] - (x_q[k-1] >>> (k - 1));
                z_d[k] = z_q[k-1] + atan_q12(unsigned'(k - 1));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            md_q  <= '0;
            for (int k = 0; k <= int'(ITER); k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                z_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            md_q  <= md_d;
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    logic                 t_vld;
    logic signed [XW-1:0] t_x, t_y;
    logic signed [ZW-1:0] t_z;

    if (GAIN_COMP != 0) begin : g_gain
        logic                 g_vld_q;
        logic signed [XW-1:0] g_x_q, g_y_q;
        logic signed [ZW-1:0] g_z_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                g_vld_q <= 1'b0;
                g_x_q   <= '0;
                g_y_q   <= '0;
                g_z_q   <= '0;
            end else if (advance) begin
                g_vld_q <= vld_q[ITER];
                g_x_q   <= scale_k(x_q[ITER]);
                g_y_q   <= scale_k(y_q[ITER]);
                g_z_q   <= z_q[ITER];
            end
        end

        assign t_vld = g_vld_q;
        assign t_x   = g_x_q;
        assign t_y   = g_y_q;
        assign t_z   = g_z_q;
    end else begin : g_no_gain
        assign t_vld = vld_q[ITER];
        assign t_x   = x_q[ITER];
        assign t_y   = y_q[ITER];
        assign t_z   = z_q[ITER];
    end

    logic                      ov_q;
    logic signed [W-1:0]       ox_q, oy_q;
    logic signed [ANGLE_W-1:0] oz_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ov_q <= 1'b0;
            ox_q <= '0;
            oy_q <= '0;
            oz_q <= '0;
        end else if (advance) begin
            ov_q <= t_vld;
            ox_q <= sat(t_x);
            oy_q <= sat(t_y);
            oz_q <= t_z[ANGLE_W-1:0];
        end
    end

    assign out_valid_o = ov_q;
    assign x_o         = ox_q;
    assign y_o         = oy_q;
    assign z_o         = oz_q;

endmodule
